// File: rtl/tlv5618_pkg.sv
// Shared types and helpers for the TLV5618 DAC channel scheduler.
package tlv5618_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StGap,
    StLoadA2
  } state_e;

  localparam logic [1:0] RC_A   = 2'b10;
  localparam logic [1:0] RC_B   = 2'b00;
  localparam logic [1:0] RC_BUF = 2'b01;

  // Control word layout: {R1, SPD, PWR, R0, code[11:0]}
  function automatic logic [15:0] pack_word(input logic [1:0] rc, input logic spd,
                                            input logic pwr, input logic [11:0] code);
    return {rc[1], spd, pwr, rc[0], code};
  endfunction

endpackage

// File: rtl/tlv5618_chan_arb.sv
// Two-way round-robin arbiter; the pointer moves to the other channel after each grant is used.
module tlv5618_chan_arb
  import tlv5618_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic pend_a_i,
  input  logic pend_b_i,
  input  logic advance_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic ptr_b_q, ptr_b_d;

  always_comb begin
    grant_a_o = pend_a_i && (!pend_b_i || !ptr_b_q);
    grant_b_o = pend_b_i && (!pend_a_i || ptr_b_q);
    ptr_b_d   = ptr_b_q;
    if (advance_i && (grant_a_o || grant_b_o)) begin
      ptr_b_d = grant_a_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_b_q <= 1'b0;
    end else begin
      ptr_b_q <= ptr_b_d;
    end
  end

endmodule

// File: rtl/tlv5618_sched.sv
// TLV5618 channel scheduler: queues A/B updates, builds control words, sequences the driver.
// Define DAC_SYNC_UPDATE_EN to issue simultaneous A/B updates as buffer-load B then latch A.
module tlv5618_sched
  import tlv5618_pkg::*;
#(
  parameter logic        FAST_MODE      = 1'b1,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_a_i,
  input  logic [11:0] data_a_i,
  input  logic        req_b_i,
  input  logic [11:0] data_b_i,
  input  logic        pwr_dn_i,
  output logic        ack_a_o,
  output logic        ack_b_o,
  output logic        ovr_a_o,
  output logic        ovr_b_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [15:0] dac_data_o,
  output logic        dac_start_o,
  input  logic        dac_done_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [11:0]     hold_a_q, hold_b_q;
  logic            infl_a_q, infl_a_d, infl_b_q, infl_b_d, sync1_q, sync1_d;
  logic            ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic            ovr_a_q, ovr_a_d, ovr_b_q, ovr_b_d, err_q, err_d;
  logic [15:0]     dac_data_q, dac_data_d;
  logic            dac_start_q, dac_start_d;
  logic            grant_a, grant_b, advance;
  logic            clr_a, clr_b, rep_a, rep_b;

  tlv5618_chan_arb u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pend_a_i  (pend_a_q),
    .pend_b_i  (pend_b_q),
    .advance_i (advance),
    .grant_a_o (grant_a),
    .grant_b_o (grant_b)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    infl_a_d    = infl_a_q;
    infl_b_d    = infl_b_q;
    sync1_d     = sync1_q;
    dac_data_d  = dac_data_q;
    dac_start_d = 1'b0;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    err_d       = err_q;
    clr_a       = 1'b0;
    clr_b       = 1'b0;
    rep_a       = 1'b0;
    rep_b       = 1'b0;
    advance     = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pend_a_q || pend_b_q) state_d = StLoad;
      end
      StLoad: begin
        cnt_d       = '0;
        state_d     = StWaitDone;
        dac_start_d = 1'b1;
`ifdef DAC_SYNC_UPDATE_EN
        if (pend_a_q && pend_b_q) begin
          dac_data_d = pack_word(RC_BUF, FAST_MODE, pwr_dn_i, hold_b_q);
          clr_b      = 1'b1;
          sync1_d    = 1'b1;
          infl_a_d   = 1'b0;
          infl_b_d   = 1'b0;
        end else
`endif
        begin
          advance    = 1'b1;
          infl_a_d   = grant_a;
          infl_b_d   = grant_b;
          clr_a      = grant_a;
          clr_b      = grant_b;
          dac_data_d = grant_a ? pack_word(RC_A, FAST_MODE, pwr_dn_i, hold_a_q)
                               : pack_word(RC_B, FAST_MODE, pwr_dn_i, hold_b_q);
        end
      end
`ifdef DAC_SYNC_UPDATE_EN
      StLoadA2: begin
        cnt_d       = '0;
        state_d     = StWaitDone;
        dac_start_d = 1'b1;
        dac_data_d  = pack_word(RC_A, FAST_MODE, pwr_dn_i, hold_a_q);
        clr_a       = 1'b1;
        sync1_d     = 1'b0;
        infl_a_d    = 1'b1;
        infl_b_d    = 1'b1;
      end
`endif
      StWaitDone: begin
        if (dac_done_i) begin
          ack_a_d  = infl_a_q;
          ack_b_d  = infl_b_q;
          infl_a_d = 1'b0;
          infl_b_d = 1'b0;
          cnt_d    = '0;
          state_d  = StGap;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Abort: put the unacknowledged value(s) back in the queue.
          err_d    = 1'b1;
          rep_a    = infl_a_q || sync1_q;
          rep_b    = infl_b_q || sync1_q;
          sync1_d  = 1'b0;
          infl_a_d = 1'b0;
          infl_b_d = 1'b0;
          cnt_d    = '0;
          state_d  = StGap;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (sync1_q)                    state_d = StLoadA2;
          else if (pend_a_q || pend_b_q) state_d = StLoad;
          else                           state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // A new request always wins over a same-cycle clear, so the fresh value stays queued.
  always_comb begin
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    ovr_a_d  = ovr_a_q;
    ovr_b_d  = ovr_b_q;
    if (clr_a) pend_a_d = 1'b0;
    if (clr_b) pend_b_d = 1'b0;
    if (rep_a) pend_a_d = 1'b1;
    if (rep_b) pend_b_d = 1'b1;
    if (req_a_i) begin
      pend_a_d = 1'b1;
      if (pend_a_q && !clr_a) ovr_a_d = 1'b1;
    end
    if (req_b_i) begin
      pend_b_d = 1'b1;
      if (pend_b_q && !clr_b) ovr_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_a_q    <= 1'b0;
      pend_b_q    <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      infl_a_q    <= 1'b0;
      infl_b_q    <= 1'b0;
      sync1_q     <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      ovr_a_q     <= 1'b0;
      ovr_b_q     <= 1'b0;
      err_q       <= 1'b0;
      dac_data_q  <= '0;
      dac_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      if (req_a_i) hold_a_q <= data_a_i;
      if (req_b_i) hold_b_q <= data_b_i;
      infl_a_q    <= infl_a_d;
      infl_b_q    <= infl_b_d;
      sync1_q     <= sync1_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      ovr_a_q     <= ovr_a_d;
      ovr_b_q     <= ovr_b_d;
      err_q       <= err_d;
      dac_data_q  <= dac_data_d;
      dac_start_q <= dac_start_d;
    end
  end

  assign ack_a_o     = ack_a_q;
  assign ack_b_o     = ack_b_q;
  assign ovr_a_o     = ovr_a_q;
  assign ovr_b_o     = ovr_b_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != StIdle);
  assign dac_data_o  = dac_data_q;
  assign dac_start_o = dac_start_q;

endmodule

// File: tb/tb_tlv5618_sched.sv
// Directed scoreboard bench for tlv5618_sched; inputs driven and outputs sampled on negedge.
module tb_tlv5618_sched;

  localparam int unsigned Gap = 5;
  localparam int unsigned Tmo = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0, pwr_dn = 1'b0, dac_done = 1'b0;
  logic [11:0] data_a = '0, data_b = '0;
  logic        ack_a, ack_b, ovr_a, ovr_b, err, busy, dac_start;
  logic [15:0] dac_data;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [17:0] sb_q[$];
  logic [17:0] cur;
  int          waited;
  int          cnt;
  logic        seen;

  always #5 clk = ~clk;

  tlv5618_sched #(
    .FAST_MODE      (1'b1),
    .GAP_CYCLES     (Gap),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_a_i     (req_a),
    .data_a_i    (data_a),
    .req_b_i     (req_b),
    .data_b_i    (data_b),
    .pwr_dn_i    (pwr_dn),
    .ack_a_o     (ack_a),
    .ack_b_o     (ack_b),
    .ovr_a_o     (ovr_a),
    .ovr_b_o     (ovr_b),
    .err_o       (err),
    .busy_o      (busy),
    .dac_data_o  (dac_data),
    .dac_start_o (dac_start),
    .dac_done_i  (dac_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] word, input logic a, input logic b);
    sb_q.push_back({b, a, word});
  endtask

  task automatic do_req(input logic ra, input logic [11:0] da, input logic rb,
                        input logic [11:0] db);
    req_a = ra; data_a = da; req_b = rb; data_b = db;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  // Waits (bounded) for a start pulse, checks its word against the scoreboard head.
  task automatic wait_start(input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      n++;
      if (dac_start) found = 1'b1;
    end
    if (!found) begin
      chk({tag, "_start_seen"}, 0, 1);
      cur = '0;
    end else if (sb_q.size() == 0) begin
      chk({tag, "_unexpected_start"}, 1, 0);
      cur = '0;
    end else begin
      cur = sb_q.pop_front();
      chk({tag, "_word"}, dac_data, cur[15:0]);
      @(negedge clk);
      chk({tag, "_start_single"}, dac_start, 0);
    end
  endtask

  task automatic finish_frame(input string tag, input int delay);
    repeat (delay) @(negedge clk);
    chk({tag, "_word_stable"}, dac_data, cur[15:0]);
    dac_done = 1'b1;
    @(negedge clk);
    dac_done = 1'b0;
    chk({tag, "_ack_a"}, ack_a, cur[16]);
    chk({tag, "_ack_b"}, ack_b, cur[17]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_flags", {ack_a, ack_b, ovr_a, ovr_b, err, busy, dac_start}, 0);
    chk("rst_data", dac_data, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Stray done while idle must be ignored.
    dac_done = 1'b1;
    @(negedge clk);
    dac_done = 1'b0;
    chk("idle_done_ack", {ack_a, ack_b}, 0);
    @(negedge clk);
    chk("idle_done_busy", busy, 0);

    // Single A, then single B.
    push(16'hC123, 1'b1, 1'b0);
    do_req(1'b1, 12'h123, 1'b0, 12'h000);
    wait_start("a1", waited);
    chk("a1_busy", busy, 1);
    finish_frame("a1", 3);
    push(16'h4ABC, 1'b0, 1'b1);
    do_req(1'b0, 12'h000, 1'b1, 12'hABC);
    wait_start("b1", waited);
    finish_frame("b1", 2);
    repeat (Gap + 2) @(negedge clk);

    // Both at once: A first (pointer back on A), then B after a full gap.
`ifdef DAC_SYNC_UPDATE_EN
    push(16'h5789, 1'b0, 1'b0);
    push(16'hC456, 1'b1, 1'b1);
`else
    push(16'hC456, 1'b1, 1'b0);
    push(16'h4789, 1'b0, 1'b1);
`endif
    do_req(1'b1, 12'h456, 1'b1, 12'h789);
    wait_start("both1_f1", waited);
    finish_frame("both1_f1", 1);
    wait_start("both1_f2", waited);
    chk("both1_gap", (waited >= Gap + 1), 1);
    finish_frame("both1_f2", 1);
    repeat (Gap + 2) @(negedge clk);

    // Lone A moves the pointer to B; next simultaneous pair must lead with B. PWR bit set.
    push(16'hC321, 1'b1, 1'b0);
    do_req(1'b1, 12'h321, 1'b0, 12'h000);
    wait_start("a2", waited);
    finish_frame("a2", 1);
    repeat (Gap + 2) @(negedge clk);
    pwr_dn = 1'b1;
`ifdef DAC_SYNC_UPDATE_EN
    push(16'h7F0F, 1'b0, 1'b0);
    push(16'hE0F0, 1'b1, 1'b1);
`else
    push(16'h6F0F, 1'b0, 1'b1);
    push(16'hE0F0, 1'b1, 1'b0);
`endif
    do_req(1'b1, 12'h0F0, 1'b1, 12'hF0F);
    wait_start("both2_f1", waited);
    finish_frame("both2_f1", 2);
    wait_start("both2_f2", waited);
    chk("both2_gap", (waited >= Gap + 1), 1);
    finish_frame("both2_f2", 2);
    pwr_dn = 1'b0;
    repeat (Gap + 2) @(negedge clk);

    // Overwrite while busy, then a timed-out frame that gets reissued.
    push(16'h45A5, 1'b0, 1'b1);
    do_req(1'b0, 12'h000, 1'b1, 12'h5A5);
    wait_start("b2", waited);
    do_req(1'b1, 12'h111, 1'b0, 12'h000);
    chk("ovr_a_first", ovr_a, 0);
    do_req(1'b1, 12'h222, 1'b0, 12'h000);
    chk("ovr_a_second", ovr_a, 1);
    finish_frame("b2", 1);
    push(16'hC222, 1'b1, 1'b0);
    wait_start("a_tmo", waited);
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < int'(Tmo) + 20 && !err; i++) begin
      @(negedge clk);
      cnt++;
      if (ack_a || ack_b) seen = 1'b1;
    end
    chk("tmo_err", err, 1);
    chk("tmo_cycles", cnt, Tmo - 1);
    chk("tmo_no_ack", seen, 0);
    push(16'hC222, 1'b1, 1'b0);
    wait_start("a_reissue", waited);
    finish_frame("a_reissue", 1);
    chk("sticky_flags", {ovr_a, ovr_b, err}, 3'b101);
    repeat (Gap + 2) @(negedge clk);

    // Reset while waiting for done.
    push(16'h4777, 1'b0, 1'b1);
    do_req(1'b0, 12'h000, 1'b1, 12'h777);
    wait_start("b_rst", waited);
    do_req(1'b0, 12'h000, 1'b1, 12'h666);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_flags", {ack_a, ack_b, ovr_a, ovr_b, err, busy, dac_start}, 0);
    chk("midrst_data", dac_data, 16'h0000);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || dac_start || ack_a || ack_b) seen = 1'b1;
    end
    chk("midrst_no_activity", seen, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
